enc8_3: RTL and testbench

- 8-to-3 binary encoder with priority resolution and registered outputs.
- Converts an 8-bit request vector into the 3-bit index of the winning set bit.
- Also reports whether any bit is set and whether more than one bit was set.
- Sits between request/interrupt style one-hot sources and index-consuming logic in the clk domain.

---
 rtl/enc8_3.sv | 66 ++++++
 tb/tb_enc8_3.sv | 139 +++++++++++++
 2 files changed

// File: rtl/enc8_3.sv
// enc8_3: 8-to-3 priority encoder with registered index, valid and multi-hot flags.
// The parameter selects which end of the request vector wins when several bits are set.
module enc8_3 #(
  parameter bit LSB_PRIORITY = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] i,
  output logic [2:0] y,
  output logic       valid,
  output logic       multi_hot
);

  logic [2:0] idx_d;
  logic       any_d;
  logic       multi_d;
  logic [3:0] pop_d;

  logic [2:0] y_q;
  logic       valid_q;
  logic       multi_q;

  // Priority search: the last match visited in the loop is the winner,
  // so the loop direction sets which end of the vector has priority.
  always_comb begin
    idx_d = 3'b000;
    if (LSB_PRIORITY) begin
      for (int k = 7; k >= 0; k--) begin
        if (i[k]) idx_d = k[2:0];
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (i[k]) idx_d = k[2:0];
      end
    end
  end

  // Population count gives both "any request" and "two or more requests".
  always_comb begin
    pop_d = 4'd0;
    for (int k = 0; k < 8; k++) begin
      pop_d = pop_d + {3'b000, i[k]};
    end
    any_d   = (pop_d != 4'd0);
    multi_d = (pop_d >= 4'd2);
  end

  // Output register: clears asynchronously, captures only when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= 3'b000;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else if (en) begin
      y_q     <= any_d ? idx_d : 3'b000;
      valid_q <= any_d;
      multi_q <= multi_d;
    end
  end

  assign y         = y_q;
  assign valid     = valid_q;
  assign multi_hot = multi_q;

endmodule

// File: tb/tb_enc8_3.sv
// tb_enc8_3: directed check of enc8_3 with both priority settings side by side.
module tb_enc8_3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] i;
  logic [2:0] y_m, y_l;
  logic       valid_m, valid_l;
  logic       multi_m, multi_l;

  int tests_run;
  int tests_failed;

  enc8_3 #(.LSB_PRIORITY(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .en(en), .i(i),
    .y(y_m), .valid(valid_m), .multi_hot(multi_m)
  );

  enc8_3 #(.LSB_PRIORITY(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .en(en), .i(i),
    .y(y_l), .valid(valid_l), .multi_hot(multi_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, obs);
    end
  endtask

  // Check all three outputs of both instances against hand-computed values.
  task automatic check_both(input string tag,
                            input logic [2:0] ey_m, input logic [2:0] ey_l,
                            input logic ev, input logic em);
    check({tag, " msb.y"},     {29'd0, y_m},     {29'd0, ey_m});
    check({tag, " msb.valid"}, {31'd0, valid_m}, {31'd0, ev});
    check({tag, " msb.multi"}, {31'd0, multi_m}, {31'd0, em});
    check({tag, " lsb.y"},     {29'd0, y_l},     {29'd0, ey_l});
    check({tag, " lsb.valid"}, {31'd0, valid_l}, {31'd0, ev});
    check({tag, " lsb.multi"}, {31'd0, multi_l}, {31'd0, em});
  endtask

  // Drive at the falling edge, sample 1 ns after the following rising edge.
  task automatic step(input logic [7:0] v, input logic e);
    @(negedge clk);
    i  = v;
    en = e;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sweep_in [9]  = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [2:0] sweep_y  [9]  = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    i     = 8'h00;

    // Held in reset across edges.
    repeat (3) @(posedge clk);
    #1;
    check_both("reset", 3'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load all-ones, then assert reset between edges.
    step(8'hFF, 1'b1);
    check_both("ff", 3'd7, 3'd0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_both("async_rst", 3'd0, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_both("rst_hold", 3'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // One-hot sweep, both instances agree on one-hot inputs.
    for (int k = 0; k < 9; k++) begin
      step(sweep_in[k], 1'b1);
      check_both($sformatf("sweep_%02h", sweep_in[k]), sweep_y[k], sweep_y[k],
                 (k != 0), 1'b0);
    end

    // Priority resolution.
    step(8'b0010_1100, 1'b1);
    check_both("prio_2c", 3'b101, 3'b010, 1'b1, 1'b1);
    step(8'hFF, 1'b1);
    check_both("prio_ff", 3'b111, 3'b000, 1'b1, 1'b1);
    step(8'b1000_0001, 1'b1);
    check_both("prio_81", 3'b111, 3'b000, 1'b1, 1'b1);

    // Enable hold.
    step(8'h10, 1'b1);
    check_both("hold_load", 3'd4, 3'd4, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(8'h02, 1'b0);
      check_both($sformatf("hold_%0d", k), 3'd4, 3'd4, 1'b1, 1'b0);
    end
    step(8'h02, 1'b1);
    check_both("hold_release", 3'd1, 3'd1, 1'b1, 1'b0);

    // Short reset pulse in the middle of a stream.
    step(8'h20, 1'b1);
    check_both("mid_pre", 3'd5, 3'd5, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_both("mid_rst", 3'd0, 3'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    i     = 8'h40;
    @(posedge clk);
    #1;
    check_both("mid_after", 3'd6, 3'd6, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #20000;
    $display("[TB] FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
